sysbus_mem_responder: RTL and testbench
=======================================

Name: sysbus_mem_responder

Overview:
- Memory-side end of the processor's multiplexed SysBus.
- Latches the address phase on ALE and decodes whether the address falls in its window.
- Services reads by driving SysBus from a synchronous RAM port, and writes by capturing SysBus data into the RAM.
- Sits between the pad/bus fabric and the on-chip SRAM macro; one instance per memory region.

Parameters:
- ADDR_W, 16, SysBus address/data width.
- BASE, 16'h0000, first word address of the responder window.
- DEPTH_LOG2, 10, window size is 2**DEPTH_LOG2 words; RAM address width.

Ports:
- Clock  input  1  system clock; all state changes on rising edge.
- nReset  input  1  asynchronous active-low reset.
- SysBusIn  input  ADDR_W  SysBus value (address in address phase, data in data phase).
- SysBusOut  output  ADDR_W  read data driven to SysBus.
- SysBusOe  output  1  high = responder drives SysBus (pad tristate enable).
- ALE  input  1  address latch enable, active high.
- nME  input  1  memory select, active low.
- nOE  input  1  output enable (read strobe), active low.
- nWE  input  1  write strobe, active low.
- RamAddr  output  DEPTH_LOG2  RAM word address (AddrReg - BASE).
- RamRe  output  1  one-cycle read request; RamRData valid the following cycle.
- RamRData  input  ADDR_W  RAM read data.
- RamWe  output  1  one-cycle write pulse.
- RamWData  output  ADDR_W  RAM write data.
- Err  output  1  sticky protocol-error flag.

Behaviour:
- Clocking and reset: single Clock; nReset is asynchronous and active-low.
  - On reset: state IDLE; AddrReg=0, Hit=0.
  - SysBusOut=0, SysBusOe=0, RamAddr=0, RamRe=0, RamWe=0, RamWData=0, Err=0.
- All outputs are registered; strobes are sampled on the rising edge.
- States: IDLE, ADDR, RDREQ, RDDRV, WRDONE.
- IDLE:
  - ALE=1 and nME=0 -> AddrReg<=SysBusIn, Hit<=(SysBusIn>=BASE && SysBusIn<BASE+2**DEPTH_LOG2), go to ADDR.
  - Otherwise stay in IDLE.
- ADDR, all conditions require nME=0:
  - Hit, nOE=0, nWE=1 -> RamRe=1 for exactly one cycle, RamAddr=AddrReg-BASE, go to RDREQ.
  - Hit, nWE=0, nOE=1 -> RamWe=1 for one cycle, RamWData=SysBusIn, RamAddr=AddrReg-BASE, go to WRDONE.
  - !Hit -> no RAM access, no drive; remain until nME=1.
  - nOE=0 and nWE=0 together -> Err<=1, no access, remain.
- RDREQ: capture RamRData into SysBusOut, set SysBusOe=1, go to RDDRV.
- RDDRV:
  - Hold SysBusOut and SysBusOe while nME=0 and nOE=0.
  - nOE=1 or nME=1 -> SysBusOe<=0, go to IDLE.
- WRDONE:
  - No further writes, even if nWE stays low (exactly one RamWe per transaction).
  - nWE=1 or nME=1 -> IDLE.
- Read latency: nOE low sampled at edge N -> RamRe high after N -> SysBusOe/SysBusOut valid after edge N+2.
- Write latency: RamWe high after the edge that samples nWE low.
- Boundary conditions:
  - nME=1 in any state -> IDLE next edge; SysBusOe<=0, RamRe<=0, RamWe<=0 (transaction aborted, no partial write).
  - ALE=1 with nME=0 in any non-IDLE state -> abort the current transaction, re-latch the address, go to ADDR; SysBusOe<=0 the same edge.
  - Address wrap: BASE+2**DEPTH_LOG2 overflowing ADDR_W is clipped to 2**ADDR_W; RamAddr is the low DEPTH_LOG2 bits of the subtraction.
  - SysBusOe is never high in the same cycle as ALE sampled high.
  - Err clears only on reset.
  - nReset asserted mid-read drops SysBusOe immediately (asynchronous).

Decomposition:
- Add to the shared opcodes package:
  - typedef enum resp_state_t {RspIdle, RspAddr, RspRdReq, RspRdDrv, RspWrDone}.
  - localparam constants for the default window.
- One natural combinational sub-module, sysbus_addr_decode (inputs AddrIn, BASE, DEPTH_LOG2; outputs Hit, RamAddr), reused by future peripheral responders.
- The FSM and output registers live in sysbus_mem_responder.

Test Plan:
- Read hit: BASE=16'h0100, ALE with SysBusIn=16'h0105, nME=0, then nOE=0 -> RamRe pulse with RamAddr=5; RamRData=16'hBEEF -> SysBusOut=16'hBEEF, SysBusOe=1 two edges after nOE sampled; nOE=1 -> SysBusOe=0 next edge.
- Write hit: ALE with 16'h0110, nWE=0 with SysBusIn=16'h1234 held 3 cycles -> exactly one RamWe, RamAddr=16'h10, RamWData=16'h1234.
- Miss: ALE with 16'h0500 (window 0x0100-0x04FF), nOE=0 -> no RamRe, SysBusOe stays 0 throughout.
- Abort: read started, nME=1 on the RDREQ cycle -> IDLE, SysBusOe never asserted; write aborted before nWE -> no RamWe.
- Protocol error: nOE=0 and nWE=0 in ADDR -> Err=1, no RAM strobe; Err persists through later valid transactions until nReset.
- Async reset: nReset low while SysBusOe=1 -> SysBusOe=0 without a clock edge; all outputs at reset values.

Source files
------------

// File: rtl/sysbus_mem_responder_pkg.sv
// Shared types and default window constants for SysBus responders.
package sysbus_mem_responder_pkg;

    // Transaction phases of a memory-side SysBus responder.
    typedef enum logic [2:0] {
        RspIdle,
        RspAddr,
        RspRdReq,
        RspRdDrv,
        RspWrDone
    } resp_state_t;

    // Default window: 1K words starting at word address 0 on a 16-bit bus.
    localparam int          DefAddrW     = 16;
    localparam logic [15:0] DefBase      = 16'h0000;
    localparam int          DefDepthLog2 = 10;

endpackage

// File: rtl/sysbus_mem_responder_if.sv
// Multiplexed SysBus signal bundle: processor side is master, memory side is slave.
interface sysbus_mem_responder_if #(
    parameter int ADDR_W = 16
);
    logic [ADDR_W-1:0] SysBusIn;
    logic [ADDR_W-1:0] SysBusOut;
    logic              SysBusOe;
    logic              ALE;
    logic              nME;
    logic              nOE;
    logic              nWE;

    modport master (
        output SysBusIn, ALE, nME, nOE, nWE,
        input  SysBusOut, SysBusOe
    );

    modport slave (
        input  SysBusIn, ALE, nME, nOE, nWE,
        output SysBusOut, SysBusOe
    );
endinterface

// File: rtl/sysbus_mem_responder_addr_decode.sv
// Window decoder: flags addresses inside [BASE, BASE + 2**DEPTH_LOG2) and
// produces the word offset into the window.
module sysbus_addr_decode
    import sysbus_mem_responder_pkg::*;
#(
    parameter int                ADDR_W     = DefAddrW,
    parameter logic [ADDR_W-1:0] BASE       = ADDR_W'(DefBase),
    parameter int                DEPTH_LOG2 = DefDepthLog2
) (
    input  logic [ADDR_W-1:0]     AddrIn,
    output logic                  Hit,
    output logic [DEPTH_LOG2-1:0] RamAddr
);
    // The window end is computed one bit wider than the bus, so a window that
    // runs past the top of the address space simply ends at 2**ADDR_W instead
    // of wrapping around to low addresses.
    localparam logic [ADDR_W:0] WinEnd = {1'b0, BASE} + ((ADDR_W + 1)'(1) << DEPTH_LOG2);

    // Range compare and offset; the offset keeps only the low DEPTH_LOG2 bits.
    always_comb begin
        Hit     = (AddrIn >= BASE) && ({1'b0, AddrIn} < WinEnd);
        RamAddr = DEPTH_LOG2'(AddrIn - BASE);
    end
endmodule

// File: rtl/sysbus_mem_responder.sv
// Memory-side SysBus responder: latches the address on ALE, then turns the
// nOE/nWE strobes into single-cycle RAM read/write requests and drives read
// data back onto the bus. All outputs are registered.
module sysbus_mem_responder
    import sysbus_mem_responder_pkg::*;
#(
    parameter int                ADDR_W     = DefAddrW,
    parameter logic [ADDR_W-1:0] BASE       = ADDR_W'(DefBase),
    parameter int                DEPTH_LOG2 = DefDepthLog2
) (
    input  logic                  Clock,
    input  logic                  nReset,
    sysbus_mem_responder_if.slave Bus,
    output logic [DEPTH_LOG2-1:0] RamAddr,
    output logic                  RamRe,
    input  logic [ADDR_W-1:0]     RamRData,
    output logic                  RamWe,
    output logic [ADDR_W-1:0]     RamWData,
    output logic                  Err
);
    resp_state_t           state, stateNxt;
    logic                  decHit;
    logic [DEPTH_LOG2-1:0] decAddr;
    // The latched address is only ever used as a window offset, so it is held
    // pre-decoded together with its hit flag.
    logic                  hitReg, hitNxt;
    logic [DEPTH_LOG2-1:0] offsetReg, offsetNxt;
    logic [ADDR_W-1:0]     busOutReg, busOutNxt;
    logic                  busOeReg, busOeNxt;
    logic [DEPTH_LOG2-1:0] ramAddrNxt;
    logic                  ramReNxt, ramWeNxt, errNxt;
    logic [ADDR_W-1:0]     ramWDataNxt;
    logic                  rdStrobe, wrStrobe, bothStrobe;

    sysbus_addr_decode #(
        .ADDR_W     (ADDR_W),
        .BASE       (BASE),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_decode (
        .AddrIn  (Bus.SysBusIn),
        .Hit     (decHit),
        .RamAddr (decAddr)
    );

    assign rdStrobe   = !Bus.nOE && Bus.nWE;
    assign wrStrobe   = !Bus.nWE && Bus.nOE;
    assign bothStrobe = !Bus.nOE && !Bus.nWE;

    assign Bus.SysBusOut = busOutReg;
    assign Bus.SysBusOe  = busOeReg;

    // State register.
    always_ff @(posedge Clock or negedge nReset) begin
        // NOTE: sequential state is only ever updated with non-blocking assignments,
        // so every register sees the pre-edge value of every other register.
        if (!nReset) state <= RspIdle;
        else         state <= stateNxt;
    end

    // Next state: deselect and re-latch take priority over the current phase.
    always_comb begin
        // NOTE: assigning a default before any branch keeps this block purely
        // combinational; a path that leaves stateNxt unassigned would infer a latch.
        stateNxt = state;
        if (Bus.nME) begin
            stateNxt = RspIdle;
        end else if (Bus.ALE) begin
            stateNxt = RspAddr;
        end else begin
            case (state)
                RspAddr: begin
                    if (hitReg && rdStrobe)      stateNxt = RspRdReq;
                    else if (hitReg && wrStrobe) stateNxt = RspWrDone;
                end
                // RamRe is high during the first RdReq cycle; the data arrives the
                // cycle after, so the phase lasts two cycles.
                RspRdReq:  if (!RamRe)   stateNxt = RspRdDrv;
                RspRdDrv:  if (Bus.nOE)  stateNxt = RspIdle;
                RspWrDone: if (Bus.nWE)  stateNxt = RspIdle;
                default:                 stateNxt = RspIdle;
            endcase
        end
    end

    // Output and datapath next values; strobes and bus drive default to off.
    always_comb begin
        hitNxt      = hitReg;
        offsetNxt   = offsetReg;
        busOutNxt   = busOutReg;
        busOeNxt    = 1'b0;
        ramAddrNxt  = RamAddr;
        ramReNxt    = 1'b0;
        ramWeNxt    = 1'b0;
        ramWDataNxt = RamWData;
        errNxt      = Err;
        if (!Bus.nME) begin
            if (Bus.ALE) begin
                hitNxt    = decHit;
                offsetNxt = decAddr;
            end else begin
                case (state)
                    RspAddr: begin
                        if (bothStrobe) begin
                            errNxt = 1'b1;
                        end else if (hitReg && rdStrobe) begin
                            ramReNxt   = 1'b1;
                            ramAddrNxt = offsetReg;
                        end else if (hitReg && wrStrobe) begin
                            ramWeNxt    = 1'b1;
                            ramAddrNxt  = offsetReg;
                            ramWDataNxt = Bus.SysBusIn;
                        end
                    end
                    RspRdReq: begin
                        if (!RamRe) begin
                            busOutNxt = RamRData;
                            busOeNxt  = 1'b1;
                        end
                    end
                    RspRdDrv: busOeNxt = !Bus.nOE;
                    default:  ;
                endcase
            end
        end
    end

    // Output and datapath registers.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            hitReg    <= 1'b0;
            offsetReg <= '0;
            busOutReg <= '0;
            busOeReg  <= 1'b0;
            RamAddr   <= '0;
            RamRe     <= 1'b0;
            RamWe     <= 1'b0;
            RamWData  <= '0;
            Err       <= 1'b0;
        end else begin
            hitReg    <= hitNxt;
            offsetReg <= offsetNxt;
            busOutReg <= busOutNxt;
            busOeReg  <= busOeNxt;
            RamAddr   <= ramAddrNxt;
            RamRe     <= ramReNxt;
            RamWe     <= ramWeNxt;
            RamWData  <= ramWDataNxt;
            Err       <= errNxt;
        end
    end
endmodule

// File: tb/tb_sysbus_mem_responder.sv
// Testbench for sysbus_mem_responder: table-driven bus cycles, hand-written
// corner sequences, then randomized transactions against a transaction-level model.
`timescale 1ns/1ps
module tb_sysbus_mem_responder;
    localparam int          AddrW     = 16;
    localparam logic [15:0] Base      = 16'h0100;
    localparam int          DepthLog2 = 10;
    localparam int          Words     = 1 << DepthLog2;

    logic                 Clock = 1'b0;
    logic                 nReset;
    logic [DepthLog2-1:0] RamAddr;
    logic                 RamRe, RamWe, Err;
    logic [AddrW-1:0]     RamRData, RamWData;

    int errors = 0;
    int checks = 0;

    sysbus_mem_responder_if #(.ADDR_W(AddrW)) bus ();

    sysbus_mem_responder #(
        .ADDR_W     (AddrW),
        .BASE       (Base),
        .DEPTH_LOG2 (DepthLog2)
    ) dut (
        .Clock    (Clock),
        .nReset   (nReset),
        .Bus      (bus),
        .RamAddr  (RamAddr),
        .RamRe    (RamRe),
        .RamRData (RamRData),
        .RamWe    (RamWe),
        .RamWData (RamWData),
        .Err      (Err)
    );

    // Stand-alone decoder whose window runs past the top of the address space.
    logic [15:0] wrapAddr;
    logic        wrapHit;
    logic [9:0]  wrapRamAddr;
    sysbus_addr_decode #(.ADDR_W(16), .BASE(16'hFF00), .DEPTH_LOG2(10)) wrapDec (
        .AddrIn  (wrapAddr),
        .Hit     (wrapHit),
        .RamAddr (wrapRamAddr)
    );

    always #5 Clock = ~Clock;

    // Unwritten RAM words read back a fixed pattern (offset 5 reads 16'hBEEF).
    function automatic logic [15:0] pattern(input logic [9:0] a);
        return 16'hBEEA ^ {6'd0, a};
    endfunction

    // Synchronous RAM environment: data valid the cycle after RamRe.
    logic [15:0] ramMem [Words];
    bit          ramValid [Words];
    always @(posedge Clock) begin
        if (RamRe) RamRData <= ramValid[RamAddr] ? ramMem[RamAddr] : pattern(RamAddr);
        if (RamWe) begin
            ramMem[RamAddr]   <= RamWData;
            ramValid[RamAddr] <= 1'b1;
        end
    end

    // Reference model of memory contents, updated from the transactions issued.
    logic [15:0] modelMem [Words];
    bit          modelValid [Words];
    bit          errExp;

    function automatic logic [15:0] expRead(input logic [9:0] off);
        return modelValid[off] ? modelMem[off] : pattern(off);
    endfunction

    task automatic modelWrite(input logic [9:0] off, input logic [15:0] d);
        modelMem[off]   = d;
        modelValid[off] = 1'b1;
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic ale, input logic nMe, input logic nOe, input logic nWe,
                         input logic [15:0] din);
        bus.ALE = ale; bus.nME = nMe; bus.nOE = nOe; bus.nWE = nWe; bus.SysBusIn = din;
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic idleStrobes(input string name);
        check1({name, " Oe"}, bus.SysBusOe, 1'b0);
        check1({name, " Re"}, RamRe, 1'b0);
        check1({name, " We"}, RamWe, 1'b0);
    endtask

    // Table vectors: ctl = {ALE, nME, nOE, nWE}, flags = {Oe, Re, We, Err};
    // negative expectations mean "not checked on this row".
    typedef struct {
        logic [3:0]  ctl;
        logic [15:0] din;
        logic [3:0]  flags;
        int          eOut;
        int          eAddr;
        int          eWd;
    } vec_t;
    vec_t vecs[$];

    task automatic addVec(input logic [3:0] ctl, input logic [15:0] din, input logic [3:0] flags,
                          input int eOut, input int eAddr, input int eWd);
        vec_t v;
        v.ctl = ctl; v.din = din; v.flags = flags; v.eOut = eOut; v.eAddr = eAddr; v.eWd = eWd;
        vecs.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state.
        nReset = 1'b0;
        drive(1'b0, 1'b1, 1'b1, 1'b1, 16'h0000);
        tick();
        tick();
        idleStrobes("reset");
        check1("reset Err", Err, 1'b0);
        check16("reset SysBusOut", bus.SysBusOut, 16'h0000);
        check16("reset RamAddr", 16'(RamAddr), 16'h0000);
        check16("reset RamWData", RamWData, 16'h0000);
        nReset = 1'b1;

        // Decoder window clipped at the top of the address space.
        wrapAddr = 16'hFF00; #1;
        check1("wrap FF00 hit", wrapHit, 1'b1);
        check16("wrap FF00 addr", 16'(wrapRamAddr), 16'h0000);
        wrapAddr = 16'hFFFF; #1;
        check1("wrap FFFF hit", wrapHit, 1'b1);
        check16("wrap FFFF addr", 16'(wrapRamAddr), 16'h00FF);
        wrapAddr = 16'hFEFF; #1;
        check1("wrap FEFF miss", wrapHit, 1'b0);
        wrapAddr = 16'h0000; #1;
        check1("wrap 0000 miss", wrapHit, 1'b0);
        wrapAddr = 16'h02FF; #1;
        check1("wrap 02FF miss", wrapHit, 1'b0);

        // Read hit at 0x0105.
        addVec(4'b1011, 16'h0105, 4'b0000, -1, -1, -1);
        addVec(4'b0001, 16'h0000, 4'b0100, -1, 5, -1);
        addVec(4'b0001, 16'h0000, 4'b0000, -1, -1, -1);
        addVec(4'b0001, 16'h0000, 4'b1000, 16'hBEEF, -1, -1);
        addVec(4'b0001, 16'h0000, 4'b1000, 16'hBEEF, -1, -1);
        addVec(4'b0011, 16'h0000, 4'b0000, -1, -1, -1);
        addVec(4'b0111, 16'h0000, 4'b0000, -1, -1, -1);
        // Write hit at 0x0110, nWE held three cycles.
        addVec(4'b1011, 16'h0110, 4'b0000, -1, -1, -1);
        addVec(4'b0010, 16'h1234, 4'b0010, -1, 16'h10, 16'h1234);
        addVec(4'b0010, 16'h1234, 4'b0000, -1, -1, -1);
        addVec(4'b0010, 16'h1234, 4'b0000, -1, -1, -1);
        addVec(4'b0011, 16'h0000, 4'b0000, -1, -1, -1);
        addVec(4'b0111, 16'h0000, 4'b0000, -1, -1, -1);
        // Miss just above the window.
        addVec(4'b1011, 16'h0500, 4'b0000, -1, -1, -1);
        addVec(4'b0001, 16'h0000, 4'b0000, -1, -1, -1);
        addVec(4'b0001, 16'h0000, 4'b0000, -1, -1, -1);
        addVec(4'b0001, 16'h0000, 4'b0000, -1, -1, -1);
        addVec(4'b0111, 16'h0000, 4'b0000, -1, -1, -1);
        // Read back the word written above.
        addVec(4'b1011, 16'h0110, 4'b0000, -1, -1, -1);
        addVec(4'b0001, 16'h0000, 4'b0100, -1, 16'h10, -1);
        addVec(4'b0001, 16'h0000, 4'b0000, -1, -1, -1);
        addVec(4'b0001, 16'h0000, 4'b1000, 16'h1234, -1, -1);
        addVec(4'b0111, 16'h0000, 4'b0000, -1, -1, -1);
        modelWrite(10'h10, 16'h1234);

        for (int i = 0; i < vecs.size(); i++) begin
            {bus.ALE, bus.nME, bus.nOE, bus.nWE} = vecs[i].ctl;
            bus.SysBusIn = vecs[i].din;
            tick();
            check1($sformatf("vec%0d Oe", i), bus.SysBusOe, vecs[i].flags[3]);
            check1($sformatf("vec%0d Re", i), RamRe, vecs[i].flags[2]);
            check1($sformatf("vec%0d We", i), RamWe, vecs[i].flags[1]);
            check1($sformatf("vec%0d Err", i), Err, vecs[i].flags[0]);
            if (vecs[i].eOut >= 0)  check16($sformatf("vec%0d SysBusOut", i), bus.SysBusOut, 16'(vecs[i].eOut));
            if (vecs[i].eAddr >= 0) check16($sformatf("vec%0d RamAddr", i), 16'(RamAddr), 16'(vecs[i].eAddr));
            if (vecs[i].eWd >= 0)   check16($sformatf("vec%0d RamWData", i), RamWData, 16'(vecs[i].eWd));
        end

        // Read aborted by nME in the request cycle: bus never driven.
        drive(1'b1, 1'b0, 1'b1, 1'b1, 16'h0120); tick();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000); tick();
        check1("abort rd Re", RamRe, 1'b1);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 16'h0000); tick();
        idleStrobes("abort rd edge1");
        tick();
        idleStrobes("abort rd edge2");

        // Write aborted before any write strobe reaches an addressed cycle.
        drive(1'b1, 1'b0, 1'b1, 1'b1, 16'h0130); tick();
        drive(1'b0, 1'b1, 1'b1, 1'b0, 16'hDEAD); tick();
        idleStrobes("abort wr edge1");
        tick();
        idleStrobes("abort wr edge2");

        // Protocol error, then a valid write with Err still held.
        drive(1'b1, 1'b0, 1'b1, 1'b1, 16'h0140); tick();
        check1("proto pre Err", Err, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000); tick();
        check1("proto Err", Err, 1'b1);
        idleStrobes("proto edge1");
        tick();
        idleStrobes("proto edge2");
        drive(1'b0, 1'b1, 1'b1, 1'b1, 16'h0000); tick();
        drive(1'b1, 1'b0, 1'b1, 1'b1, 16'h0141); tick();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 16'h5A5A); tick();
        check1("post-err We", RamWe, 1'b1);
        check16("post-err RamAddr", 16'(RamAddr), 16'h0041);
        check1("post-err Err sticky", Err, 1'b1);
        modelWrite(10'h41, 16'h5A5A);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 16'h0000); tick();

        // Re-latch with ALE while driving: drive drops on the ALE edge.
        drive(1'b1, 1'b0, 1'b1, 1'b1, 16'h0150); tick();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000); tick(); tick(); tick();
        check1("relatch pre Oe", bus.SysBusOe, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 16'h0151); tick();
        check1("relatch ALE Oe", bus.SysBusOe, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000); tick();
        check1("relatch Re", RamRe, 1'b1);
        check16("relatch RamAddr", 16'(RamAddr), 16'h0051);
        tick(); tick();
        check1("relatch Oe", bus.SysBusOe, 1'b1);
        check16("relatch SysBusOut", bus.SysBusOut, expRead(10'h51));
        drive(1'b0, 1'b1, 1'b1, 1'b1, 16'h0000); tick();

        // Asynchronous reset in the middle of a driven read.
        drive(1'b1, 1'b0, 1'b1, 1'b1, 16'h0160); tick();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000); tick(); tick(); tick();
        check1("areset pre Oe", bus.SysBusOe, 1'b1);
        #2 nReset = 1'b0;
        #1;
        idleStrobes("areset");
        check1("areset Err", Err, 1'b0);
        check16("areset SysBusOut", bus.SysBusOut, 16'h0000);
        check16("areset RamAddr", 16'(RamAddr), 16'h0000);
        check16("areset RamWData", RamWData, 16'h0000);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 16'h0000);
        tick();
        nReset = 1'b1;
        errExp = 1'b0;

        // Randomized transactions against the transaction-level model.
        for (int t = 0; t < 60; t++) begin
            int          kind, sel, len;
            logic [15:0] addr, data;
            logic [9:0]  off;
            bit          hit;
            kind = $urandom_range(0, 9);
            sel  = $urandom_range(0, 9);
            case (sel)
                0:       addr = 16'h00FF;
                1:       addr = 16'h0500;
                2:       addr = 16'h0100;
                3:       addr = 16'h04FF;
                4:       addr = 16'($urandom);
                default: addr = Base + 16'($urandom_range(0, Words - 1));
            endcase
            hit = (int'(addr) >= int'(Base)) && (int'(addr) < int'(Base) + Words);
            off = 10'(addr - Base);
            if (!hit && kind == 9) kind = 0;

            drive(1'b1, 1'b0, 1'b1, 1'b1, addr); tick();
            idleStrobes($sformatf("rnd%0d addr", t));

            if (kind <= 4) begin
                len = $urandom_range(3, 6);
                for (int j = 1; j <= len; j++) begin
                    drive(1'b0, 1'b0, 1'b0, 1'b1, 16'($urandom)); tick();
                    check1($sformatf("rnd%0d rd Re j%0d", t, j), RamRe, hit && j == 1);
                    if (hit && j == 1) check16($sformatf("rnd%0d rd RamAddr", t), 16'(RamAddr), 16'(off));
                    check1($sformatf("rnd%0d rd Oe j%0d", t, j), bus.SysBusOe, hit && j >= 3);
                    if (hit && j >= 3) check16($sformatf("rnd%0d rd data j%0d", t, j), bus.SysBusOut, expRead(off));
                end
                drive(1'b0, 1'b0, 1'b1, 1'b1, 16'h0000); tick();
                check1($sformatf("rnd%0d rd release Oe", t), bus.SysBusOe, 1'b0);
            end else if (kind <= 7) begin
                data = 16'($urandom);
                len  = $urandom_range(1, 4);
                for (int j = 1; j <= len; j++) begin
                    drive(1'b0, 1'b0, 1'b1, 1'b0, data); tick();
                    check1($sformatf("rnd%0d wr We j%0d", t, j), RamWe, hit && j == 1);
                    if (hit && j == 1) begin
                        check16($sformatf("rnd%0d wr RamAddr", t), 16'(RamAddr), 16'(off));
                        check16($sformatf("rnd%0d wr RamWData", t), RamWData, data);
                    end
                    check1($sformatf("rnd%0d wr Oe j%0d", t, j), bus.SysBusOe, 1'b0);
                end
                if (hit) modelWrite(off, data);
            end else if (kind == 8) begin
                drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000); tick();
                check1($sformatf("rnd%0d abort Re", t), RamRe, hit);
                drive(1'b0, 1'b1, 1'b0, 1'b1, 16'h0000); tick();
                idleStrobes($sformatf("rnd%0d abort", t));
            end else begin
                drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000); tick();
                errExp = 1'b1;
                idleStrobes($sformatf("rnd%0d proto", t));
                check1($sformatf("rnd%0d proto Err", t), Err, 1'b1);
            end

            drive(1'b0, 1'b1, 1'b1, 1'b1, 16'h0000); tick();
            idleStrobes($sformatf("rnd%0d idle", t));
            check1($sformatf("rnd%0d idle Err", t), Err, errExp);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
